game_collision_ctrl: RTL
========================

Name: game_collision_ctrl

Overview:
Central game-state controller. Consumes Mario's tile position and the tile positions of the two mushroom movers, and produces the 2-bit game_state that drives both mushroom mover blocks and the Mario mover. Detects stomp kills and side hits, and tracks lives, score and win/lose. It runs the start/respawn/freeze/game-over sequence so that the movers reset on GAME_START and stop on GAME_END.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..3)
STOMP_PTS, 10, score added per mushroom stomped
FREEZE_CYCLES, 100_000_000, clk cycles spent frozen after a side hit (27-bit counter)
GOAL_X, 31, Mario tile x that wins the level

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start_btn  in  1  level from debounced button; rising edge detected internally
mario_x  in  5  Mario tile column
mario_y  in  5  Mario tile row (y grows downward)
mario_falling  in  1  Mario moving downward this cycle
m0_x, m0_y  in  5 each  mushroom 0 tile position
m1_x, m1_y  in  5 each  mushroom 1 tile position
game_state  out  2  0=GAME_END, 1=GAME_ING, 2=GAME_START
mashroom_alive  out  2  bit i = mushroom i alive (display/collision enable)
lives  out  2  remaining lives
score  out  8  saturating score
win  out  1  level cleared flag
hit_pulse  out  1  one-cycle pulse on side hit

Behaviour:
- Reset values: state START, game_state=2, mashroom_alive=2'b11, lives=LIVES_INIT, score=0, win=0, hit_pulse=0, freeze counter=0, start edge register=0. Reset overrides everything, including mid-freeze.
- start_edge = start_btn & ~start_btn_q; start_btn_q is registered every cycle.
- Internal states and game_state mapping:
  - START (2): waits for start_edge.
  - PLAY (1): collision detection active.
  - FREEZE (0): counts FREEZE_CYCLES.
  - RESPAWN (2): lasts exactly one cycle.
  - OVER (0): terminal until restart.
- All outputs are registered. A collision visible on inputs at edge N is reflected in outputs after edge N+1.
- START --start_edge--> PLAY. On that transition: lives=LIVES_INIT, score=0, alive=11, win=0.
- Per mushroom i, evaluated only in PLAY and only if alive[i]:
  - stomp_i = mario_falling & (mario_x==mi_x) & (mario_y+1==mi_y). The +1 is 5-bit; mario_y=31 never stomps (no wrap match).
  - side_i = (mario_x==mi_x) & (mario_y==mi_y).
- PLAY priority, highest first:
  1. Any side_i: lives-=1, hit_pulse=1, counter cleared, go to FREEZE. All stomps in the same cycle are ignored (no kill, no score).
  2. Any stomp_i: clear alive[i]. score += STOMP_PTS per stomped mushroom; both in one cycle adds 2*STOMP_PTS, saturating at 255. If alive becomes 00: win=1, go to OVER.
  3. mario_x==GOAL_X: win=1, go to OVER.
- FREEZE: counter increments each cycle. On counter==FREEZE_CYCLES-1: if lives==0 go to OVER (win=0), else go to RESPAWN. start_btn is ignored.
- RESPAWN: game_state=2 for one cycle (movers reload start positions), then PLAY. alive bits are not restored; killed mushrooms stay dead.
- OVER --start_edge--> START. No other exit.
- A level-high start_btn produces only one edge. A held button never skips START.
- lives never underflows; the decrement only occurs in PLAY, where lives>=1.

Test Plan:
1. Reset, then start_btn pulse → game_state 2→1 two edges later; lives=3, score=0, alive=11.
2. PLAY, mario=(10,11) falling, m0=(10,12) → next cycle alive=10, score=10, game_state stays 1; stomp m1 later → alive=00, score=20, win=1, game_state=0.
3. FREEZE_CYCLES=8, mario=m0=(24,12) → hit_pulse one cycle, lives=2, game_state=0 for 8 cycles, then 2 for 1 cycle, then 1.
4. Three side hits with LIVES_INIT=3 → after third freeze, game_state=0 (OVER), lives=0, win=0; start_btn edge → 2; second edge → 1 with lives=3.
5. Same cycle: stomp m0 and side hit m1 → alive unchanged (11), score unchanged, lives decremented, FREEZE entered.
6. score=250, STOMP_PTS=10, stomp → score=255; assert reset during FREEZE → game_state=2, lives=3, score=0 next cycle.

Source files
------------

// File: rtl/game_collision_ctrl.sv
// Central game-state controller: stomp/side-hit detection, lives, score, win/lose
// and the start/freeze/respawn/game-over sequence that drives the mover blocks.
module game_collision_ctrl #(
    parameter int unsigned LIVES_INIT    = 3,
    parameter int unsigned STOMP_PTS     = 10,
    parameter int unsigned FREEZE_CYCLES = 100_000_000,
    parameter int unsigned GOAL_X        = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [4:0] mario_x,
    input  logic [4:0] mario_y,
    input  logic       mario_falling,
    input  logic [4:0] m0_x,
    input  logic [4:0] m0_y,
    input  logic [4:0] m1_x,
    input  logic [4:0] m1_y,
    output logic [1:0] game_state,
    output logic [1:0] mashroom_alive,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       win,
    output logic       hit_pulse
);

    localparam int unsigned POS_W   = 5;
    localparam int unsigned CNT_W   = 27;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned SUM_W   = 10;

    localparam logic [1:0] GS_END   = 2'd0;
    localparam logic [1:0] GS_ING   = 2'd1;
    localparam logic [1:0] GS_START = 2'd2;

    typedef enum logic [2:0] {
        ST_START,
        ST_PLAY,
        ST_FREEZE,
        ST_RESPAWN,
        ST_OVER
    } state_t;

    state_t               state_q, state_d;
    logic                 start_btn_q;
    logic                 start_edge;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           lives_q, lives_d;
    logic [1:0]           alive_q, alive_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 win_q, win_d;
    logic                 hit_q, hit_d;
    logic [1:0]           stomp, side;
    logic [SUM_W-1:0]     score_sum;
    logic                 freeze_done;
    logic                 at_goal;
    logic [1:0]           game_state_c;

    assign start_edge  = start_btn & ~start_btn_q;
    assign freeze_done = (cnt_q == CNT_W'(FREEZE_CYCLES - 1));
    assign at_goal     = (mario_x == POS_W'(GOAL_X));

    // Collision terms; the row-31 guard keeps the 5-bit y+1 from wrapping onto row 0.
    always_comb begin
        stomp = '0;
        side  = '0;
        if (state_q == ST_PLAY) begin
            side[0]  = alive_q[0] & (mario_x == m0_x) & (mario_y == m0_y);
            side[1]  = alive_q[1] & (mario_x == m1_x) & (mario_y == m1_y);
            stomp[0] = alive_q[0] & mario_falling & (mario_x == m0_x) & (mario_y != '1)
                       & (POS_W'(mario_y + POS_W'(1)) == m0_y);
            stomp[1] = alive_q[1] & mario_falling & (mario_x == m1_x) & (mario_y != '1)
                       & (POS_W'(mario_y + POS_W'(1)) == m1_y);
        end
    end

    assign score_sum = SUM_W'(score_q)
                     + (stomp[0] ? SUM_W'(STOMP_PTS) : SUM_W'(0))
                     + (stomp[1] ? SUM_W'(STOMP_PTS) : SUM_W'(0));

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_START;
        else       state_q <= state_d;
    end

    // Side hits outrank stomps, stomps outrank reaching the goal column.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START:   if (start_edge) state_d = ST_PLAY;
            ST_PLAY: begin
                if (|side) begin
                    state_d = ST_FREEZE;
                end else if (|stomp) begin
                    if ((alive_q & ~stomp) == 2'b00) state_d = ST_OVER;
                end else if (at_goal) begin
                    state_d = ST_OVER;
                end
            end
            ST_FREEZE:  if (freeze_done) state_d = (lives_q == 2'd0) ? ST_OVER : ST_RESPAWN;
            ST_RESPAWN: state_d = ST_PLAY;
            ST_OVER:    if (start_edge) state_d = ST_START;
            default:    state_d = ST_START;
        endcase
    end

    always_comb begin
        case (state_q)
            ST_PLAY:             game_state_c = GS_ING;
            ST_FREEZE, ST_OVER:  game_state_c = GS_END;
            default:             game_state_c = GS_START;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        lives_d = lives_q;
        alive_d = alive_q;
        score_d = score_q;
        win_d   = win_q;
        hit_d   = 1'b0;
        case (state_q)
            ST_START: begin
                if (start_edge) begin
                    lives_d = 2'(LIVES_INIT);
                    alive_d = 2'b11;
                    score_d = '0;
                    win_d   = 1'b0;
                end
            end
            ST_PLAY: begin
                if (|side) begin
                    lives_d = lives_q - 2'd1;
                    hit_d   = 1'b1;
                    cnt_d   = '0;
                end else if (|stomp) begin
                    alive_d = alive_q & ~stomp;
                    score_d = (score_sum > SUM_W'(8'hFF)) ? '1 : score_sum[SCORE_W-1:0];
                    if (alive_d == 2'b00) win_d = 1'b1;
                end else if (at_goal) begin
                    win_d = 1'b1;
                end
            end
            ST_FREEZE: cnt_d = cnt_q + CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_btn_q <= 1'b0;
            cnt_q       <= '0;
            lives_q     <= 2'(LIVES_INIT);
            alive_q     <= 2'b11;
            score_q     <= '0;
            win_q       <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            start_btn_q <= start_btn;
            cnt_q       <= cnt_d;
            lives_q     <= lives_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            win_q       <= win_d;
            hit_q       <= hit_d;
        end
    end

    // Output stage: every visible signal lags the internal state by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_state     <= GS_START;
            mashroom_alive <= 2'b11;
            lives          <= 2'(LIVES_INIT);
            score          <= '0;
            win            <= 1'b0;
            hit_pulse      <= 1'b0;
        end else begin
            game_state     <= game_state_c;
            mashroom_alive <= alive_q;
            lives          <= lives_q;
            score          <= score_q;
            win            <= win_q;
            hit_pulse      <= hit_q;
        end
    end

endmodule
